// File: rtl/tt10_chronospatial_pkg.sv
// rtl/tt10_chronospatial_pkg.sv - shared types, codes and cursor step helper for the chronospatial tracker
package tt10_chronospatial_pkg;

    typedef enum logic [1:0] {
        DIR_XP = 2'b00,
        DIR_XM = 2'b01,
        DIR_YP = 2'b10,
        DIR_YM = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        SEL_POS        = 3'd0,
        SEL_TS_LO      = 3'd1,
        SEL_TS_HI      = 3'd2,
        SEL_SNAP_POS   = 3'd3,
        SEL_SNAP_TS_LO = 3'd4,
        SEL_SNAP_TS_HI = 3'd5,
        SEL_MOVE_CNT   = 3'd6,
        SEL_STATUS     = 3'd7
    } sel_e;

    localparam int HIST_DEPTH = 4;

    // Packed cursor position {y[3:0], x[3:0]}
    typedef logic [7:0] pos_t;

    // One step on the 16x16 torus; the 4-bit arithmetic provides the wrap
    function automatic pos_t step_pos(input pos_t p, input dir_e d);
        logic [3:0] x;
        logic [3:0] y;
        x = p[3:0];
        y = p[7:4];
        case (d)
            DIR_XP: x = x + 4'd1;
            DIR_XM: x = x - 4'd1;
            DIR_YP: y = y + 4'd1;
            DIR_YM: y = y - 4'd1;
        endcase
        return {y, x};
    endfunction

endpackage

// File: rtl/tt10_chronospatial_history.sv
// rtl/tt10_chronospatial_history.sv - 4-entry position LIFO that drops its oldest entry on overflow
module tt10_chronospatial_history
    import tt10_chronospatial_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  pos_t       push_pos,
    output pos_t       top_pos,
    output logic [2:0] depth
);

    // stack[0] is the top; pushing shifts everything down so the oldest falls off the end
    pos_t stack [HIST_DEPTH];

    // Shift-register stack with a saturating depth count; clear wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) stack[i] <= '0;
            depth <= 3'd0;
        end else if (clear) begin
            for (int i = 0; i < HIST_DEPTH; i++) stack[i] <= '0;
            depth <= 3'd0;
        end else if (push) begin
            stack[0] <= push_pos;
            for (int i = 1; i < HIST_DEPTH; i++) stack[i] <= stack[i-1];
            if (depth != 3'(HIST_DEPTH)) depth <= depth + 3'd1;
        end else if (pop && depth != 3'd0) begin
            for (int i = 0; i < HIST_DEPTH - 1; i++) stack[i] <= stack[i+1];
            stack[HIST_DEPTH-1] <= '0;
            depth <= depth - 3'd1;
        end
    end

    assign top_pos = stack[0];

endmodule

// File: rtl/tt10_chronospatial_ironisland.sv
// rtl/tt10_chronospatial_ironisland.sv - toroidal cursor tracker with timestamp snapshots; CHRONO_REWIND_EN adds rewind history
module tt10_chronospatial_ironisland
    import tt10_chronospatial_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0]  dir_q;
    logic [3:0]  str_q;      // {clear, rewind, snapshot, move}
    logic [3:0]  str_qq;
    logic [3:0]  str_in;
    logic        move_rise;
    logic        snap_rise;
    logic        rew_rise;
    logic        clr_rise;
    pos_t        pos;
    pos_t        snap_pos;
    logic [15:0] ts;
    logic [15:0] snap_ts;
    logic [7:0]  move_cnt;
    logic        snap_valid;
    logic        at_origin;
    logic [2:0]  hist_depth;
    logic [7:0]  status;
    logic        rew_allowed;
    pos_t        hist_top;

`ifdef CHRONO_REWIND_EN
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:1]};
    assign str_in = {ui_in[7], uio_in[0], ui_in[3:2]};

    tt10_chronospatial_history u_history (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ena & clr_rise),
        .push     (ena & move_rise & ~clr_rise),
        .pop      (ena & rew_rise & ~move_rise & ~clr_rise),
        .push_pos (pos),
        .top_pos  (hist_top),
        .depth    (hist_depth)
    );
    assign rew_allowed = (hist_depth != 3'd0);
`else
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in, str_qq[2]};
    assign str_in      = {ui_in[7], 1'b0, ui_in[3:2]};
    assign hist_depth  = 3'd0;
    assign hist_top    = '0;
    assign rew_allowed = 1'b0;
`endif

    assign move_rise = str_q[0] & ~str_qq[0];
    assign snap_rise = str_q[1] & ~str_qq[1];
    assign rew_rise  = str_q[2] & ~str_qq[2];
    assign clr_rise  = str_q[3] & ~str_qq[3];

    // Two-stage strobe sampling for rising-edge detection; dir rides with the first stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= 2'b00;
            str_q  <= 4'b0000;
            str_qq <= 4'b0000;
        end else if (ena) begin
            dir_q  <= ui_in[1:0];
            str_q  <= str_in;
            str_qq <= str_q;
        end
    end

    // Cursor, timestamp and snapshot state; clear beats move, move beats rewind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts         <= 16'h0000;
            pos        <= '0;
            move_cnt   <= 8'h00;
            snap_pos   <= '0;
            snap_ts    <= 16'h0000;
            snap_valid <= 1'b0;
        end else if (ena) begin
            ts <= ts + 16'd1;
            if (clr_rise) begin
                pos        <= '0;
                move_cnt   <= 8'h00;
                snap_pos   <= '0;
                snap_ts    <= 16'h0000;
                snap_valid <= 1'b0;
            end else begin
                if (move_rise) begin
                    pos <= step_pos(pos, dir_e'(dir_q));
                    if (move_cnt != 8'hFF) move_cnt <= move_cnt + 8'd1;
                end else if (rew_rise && rew_allowed) begin
                    pos <= hist_top;
                end
                if (snap_rise) begin
                    snap_pos   <= pos;
                    snap_ts    <= ts;
                    snap_valid <= 1'b1;
                end
            end
        end
    end

    assign at_origin = (pos == 8'h00);
    assign status    = {snap_valid, at_origin, hist_depth, 3'b000};

    // Zero-latency readout mux driven straight from the select pins
    always_comb begin
        uo_out = 8'h00;
        case (sel_e'(ui_in[6:4]))
            SEL_POS:        uo_out = pos;
            SEL_TS_LO:      uo_out = ts[7:0];
            SEL_TS_HI:      uo_out = ts[15:8];
            SEL_SNAP_POS:   uo_out = snap_pos;
            SEL_SNAP_TS_LO: uo_out = snap_ts[7:0];
            SEL_SNAP_TS_HI: uo_out = snap_ts[15:8];
            SEL_MOVE_CNT:   uo_out = move_cnt;
            SEL_STATUS:     uo_out = status;
            default:        uo_out = 8'h00;
        endcase
    end

    assign uio_out = status;
    assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt10_chronospatial_ironisland.sv
// tb/tb_tt10_chronospatial_ironisland.sv - directed scoreboard bench for tt10_chronospatial_ironisland
`timescale 1ns/1ps
module tb_tt10_chronospatial_ironisland;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        int         kind;   // 0 uo_out via select, 1 uio_out, 2 uio_oe
        logic [2:0] sel;
        logic [7:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_ts;
    logic [15:0] snap_exp;
    logic [15:0] ts_frozen;
    logic [2:0]  exp_depth;

    tt10_chronospatial_ironisland dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference timestamp: counts enabled edges, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ts <= 16'h0000;
        else if (ena) m_ts <= m_ts + 16'd1;
    end

    function automatic logic [7:0] stat(input logic sv, input logic ao, input logic [2:0] d);
        return {sv, ao, d, 3'b000};
    endfunction

    task automatic exp_sel(input string tag, input logic [2:0] sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag; e.kind = 0; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_pin(input string tag, input int kind, input logic [7:0] val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.sel = 3'd0; e.val = val;
        sb.push_back(e);
    endtask

    // Compare every queued expectation during the current low phase, then realign to a negedge
    task automatic drain();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) begin
                ui_in[6:4] = e.sel;
                #1;
                obs = uo_out;
            end else if (e.kind == 1) begin
                obs = uio_out;
            end else begin
                obs = uio_oe;
            end
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
        ui_in[6:4] = 3'd0;
        @(negedge clk);
    endtask

    // Hold strobe bits for two edges, then drop them for one; snap_exp is the ts a snapshot captures
    task automatic strobe(input logic [7:0] mask, input logic rew);
        ui_in  = (ui_in & 8'h70) | mask;
        uio_in = {7'b0, rew};
        @(negedge clk);
        snap_exp = m_ts;
        @(negedge clk);
        ui_in  = ui_in & 8'h70;
        uio_in = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        exp_depth = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_sel("reset_pos", 3'd0, 8'h00);
        exp_pin("reset_uio_out", 1, 8'h40);
        exp_pin("reset_uio_oe", 2, 8'hFE);
        exp_sel("reset_cnt", 3'd6, 8'h00);
        exp_sel("reset_ts_lo", 3'd1, m_ts[7:0]);
        drain();

        // x-1 from origin wraps to 15
        strobe(8'h05, 1'b0);
        exp_sel("move_xm_wrap", 3'd0, 8'h0F);
        drain();

        // sixteen y+1 steps wrap y back around
        for (int i = 0; i < 16; i++) strobe(8'h06, 1'b0);
`ifdef CHRONO_REWIND_EN
        exp_depth = 3'd4;
`endif
        exp_sel("y_wrap_pos", 3'd0, 8'h0F);
        exp_sel("cnt_17", 3'd6, 8'd17);
        drain();

        // snapshot with a simultaneous x+1 move keeps the pre-move position
        while (m_ts < 16'd300) @(negedge clk);
        strobe(8'h0C, 1'b0);
        exp_sel("snap_ts_hi", 3'd5, snap_exp[15:8]);
        exp_sel("snap_ts_hi_01", 3'd5, 8'h01);
        exp_sel("snap_ts_lo", 3'd4, snap_exp[7:0]);
        exp_sel("snap_pos_premove", 3'd3, 8'h0F);
        exp_sel("pos_after_snapmove", 3'd0, 8'h00);
        exp_sel("cnt_18", 3'd6, 8'd18);
        exp_sel("status_snap", 3'd7, stat(1'b1, 1'b1, exp_depth));
        drain();

        // move count saturates at 255
        for (int i = 0; i < 260; i++) strobe(8'h04, 1'b0);
        exp_sel("cnt_sat", 3'd6, 8'hFF);
        exp_sel("pos_after_260", 3'd0, 8'h04);
        exp_pin("status_pin_sat", 1, stat(1'b1, 1'b0, exp_depth));
        drain();

        // clear together with a move: clear wins, ts keeps running
        strobe(8'h84, 1'b0);
        exp_depth = 3'd0;
        exp_sel("clr_pos", 3'd0, 8'h00);
        exp_sel("clr_cnt", 3'd6, 8'h00);
        exp_sel("clr_snap_pos", 3'd3, 8'h00);
        exp_sel("clr_snap_ts", 3'd4, 8'h00);
        exp_sel("clr_status", 3'd7, 8'h40);
        exp_sel("clr_ts_lo", 3'd1, m_ts[7:0]);
        exp_sel("clr_ts_hi", 3'd2, m_ts[15:8]);
        drain();

        // ena low: nothing moves, strobes ignored
        ts_frozen = m_ts;
        ena = 1'b0;
        for (int i = 0; i < 17; i++) strobe((i % 2 == 0) ? 8'h0C : 8'h84, 1'b0);
        exp_sel("ena0_ts_lo", 3'd1, ts_frozen[7:0]);
        exp_sel("ena0_ts_hi", 3'd2, ts_frozen[15:8]);
        exp_sel("ena0_pos", 3'd0, 8'h00);
        exp_sel("ena0_cnt", 3'd6, 8'h00);
        exp_sel("ena0_status", 3'd7, 8'h40);
        drain();
        ena = 1'b1;
        @(negedge clk);

        // y-1 from origin after re-enable
        strobe(8'h07, 1'b0);
`ifdef CHRONO_REWIND_EN
        exp_depth = 3'd1;
`endif
        exp_sel("reena_pos", 3'd0, 8'hF0);
        exp_sel("reena_cnt", 3'd6, 8'h01);
        exp_sel("reena_ts_lo", 3'd1, m_ts[7:0]);
        drain();

        // reset between strobe capture and action: the pending move must vanish
        ui_in = 8'h04;
        @(posedge clk);
        #10 rst_n = 1'b0;
        #10 ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_depth = 3'd0;
        repeat (3) @(negedge clk);
        exp_sel("rst_mid_pos", 3'd0, 8'h00);
        exp_sel("rst_mid_cnt", 3'd6, 8'h00);
        exp_pin("rst_mid_uio", 1, 8'h40);
        exp_sel("rst_mid_ts", 3'd1, m_ts[7:0]);
        drain();

`ifdef CHRONO_REWIND_EN
        for (int i = 0; i < 5; i++) strobe(8'h04, 1'b0);
        exp_sel("rew_x5", 3'd0, 8'h05);
        exp_pin("rew_depth4", 1, stat(1'b0, 1'b0, 3'd4));
        drain();
        for (int i = 0; i < 5; i++) begin
            strobe(8'h00, 1'b1);
            exp_sel($sformatf("rew_pos_%0d", i), 3'd0, (i < 4) ? 8'(4 - i) : 8'h01);
            exp_pin($sformatf("rew_depth_%0d", i), 1, stat(1'b0, 1'b0, (i < 4) ? 3'(3 - i) : 3'd0));
            exp_sel($sformatf("rew_cnt_%0d", i), 3'd6, 8'd5);
            drain();
        end
        strobe(8'h04, 1'b1);
        exp_sel("move_beats_rew", 3'd0, 8'h02);
        exp_pin("move_beats_rew_depth", 1, stat(1'b0, 1'b0, 3'd1));
        drain();
`else
        strobe(8'h00, 1'b1);
        exp_sel("uio_ignored_pos", 3'd0, 8'h00);
        exp_pin("uio_ignored_status", 1, 8'h40);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
